// File: rtl/sketch_pkg.sv
// sketch_pkg: shared sketch geometry, export-frame constants and the export
// FSM state type. Also imported by the lookup block that updates the sketch.
package sketch_pkg;
    localparam int ROWS          = 4;
    localparam int WIDTH         = 1024;
    localparam int CNT_WIDTH     = 32;
    localparam int SKETCH_ADDR_W = $clog2(ROWS * WIDTH);

    localparam logic [31:0] SKETCH_MAGIC = 32'h534B4554;  // "SKET"

    // Counters packed per stream beat, and the derived beat-index geometry.
    localparam int LANES     = 16;
    localparam int LANE_W    = $clog2(LANES);
    localparam int BEAT_W    = SKETCH_ADDR_W - LANE_W;
    localparam int NUM_BEATS = ROWS * WIDTH / LANES;

    typedef enum logic [2:0] {
        EXP_IDLE,
        EXP_HEADER,
        EXP_FILL,
        EXP_SEND,
        EXP_DONE
    } export_state_e;
endpackage

// File: rtl/sketch_export_if.sv
// sketch_export_if: AXI-Stream bundle carrying the sketch export frame.
//   tdata/tkeep/tuser/tvalid/tlast : master -> slave
//   tready                         : slave  -> master
interface sketch_export_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 128
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/sketch_export.sv
// sketch_export: walks the whole count-min sketch through the RAM's second
// port and emits it as one AXI-Stream frame (header beat + 16 counters per
// data beat). Optionally zeroes each counter right after it is read.
// Ports:
//   axis_aclk, axis_resetn     clock, async active-low reset
//   export_start/clear_on_read start pulse, clear mode sampled at start
//   export_busy/export_done    busy level, one-cycle completion pulse
//   export_seq                 sequence number of last completed export
//   sk_rd_en/addr/data         sketch read port, data one cycle after enable
//   sk_clr_en/addr             sketch zero-write port
//   m_axis                     AXI-Stream master toward the CPU DMA queue
module sketch_export
    import sketch_pkg::*;
#(
    parameter int         C_M_AXIS_DATA_WIDTH  = 512,
    parameter int         C_M_AXIS_TUSER_WIDTH = 128,
    parameter int         DST_PORT_POS         = 24,
    parameter logic [7:0] EXPORT_DST_PORT      = 8'h02
) (
    input  logic                     axis_aclk,
    input  logic                     axis_resetn,
    input  logic                     export_start,
    input  logic                     clear_on_read,
    output logic                     export_busy,
    output logic                     export_done,
    output logic [15:0]              export_seq,
    output logic                     sk_rd_en,
    output logic [SKETCH_ADDR_W-1:0] sk_rd_addr,
    input  logic [CNT_WIDTH-1:0]     sk_rd_data,
    output logic                     sk_clr_en,
    output logic [SKETCH_ADDR_W-1:0] sk_clr_addr,
    sketch_export_if.master          m_axis
);
    localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    localparam logic [C_M_AXIS_TUSER_WIDTH-1:0] TUSER_C =
        C_M_AXIS_TUSER_WIDTH'(EXPORT_DST_PORT) << DST_PORT_POS;

    export_state_e state, state_nxt;

    logic [BEAT_W-1:0]                 beat_idx;
    logic [LANE_W:0]                   rd_cnt;    // reads issued this beat, 0..LANES
    logic                              cap_vld;   // read data valid this cycle
    logic [LANE_W-1:0]                 cap_lane;
    logic                              clr_lat;
    logic [15:0]                       seq;
    logic [LANES-1:0][CNT_WIDTH-1:0]   beat;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    hdr;

    wire handshake = m_axis.tvalid & m_axis.tready;
    wire fill_end  = rd_cnt[LANE_W];  // last lane is being captured

    // State register
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) state <= EXP_IDLE;
        else              state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            EXP_IDLE:   if (export_start) state_nxt = EXP_HEADER;
            EXP_HEADER: if (m_axis.tready) state_nxt = EXP_FILL;
            EXP_FILL:   if (fill_end) state_nxt = EXP_SEND;
            EXP_SEND:   if (m_axis.tready)
                            state_nxt = (beat_idx == LAST_BEAT) ? EXP_DONE : EXP_FILL;
            EXP_DONE:   state_nxt = EXP_IDLE;
            default:    state_nxt = EXP_IDLE;
        endcase
    end

    // Output logic. Reads happen only in FILL, so SEND can stall on tready
    // while the beat register simply holds.
    always_comb begin
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tlast  = 1'b0;
        export_done   = 1'b0;
        sk_rd_en      = 1'b0;
        unique case (state)
            EXP_HEADER: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = hdr;
            end
            EXP_FILL:   sk_rd_en = ~fill_end;
            EXP_SEND: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = beat;
                m_axis.tlast  = (beat_idx == LAST_BEAT);
            end
            EXP_DONE:   export_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        hdr          = '0;
        hdr[31:0]    = SKETCH_MAGIC;
        hdr[47:32]   = seq;
        hdr[63:48]   = 16'(ROWS);
        hdr[95:64]   = 32'(WIDTH);
    end

    assign m_axis.tkeep = {KEEP_W{m_axis.tvalid}};
    assign m_axis.tuser = TUSER_C;
    assign export_busy  = (state != EXP_IDLE);
    assign sk_rd_addr   = sk_rd_en ? {beat_idx, rd_cnt[LANE_W-1:0]} : '0;
    assign sk_clr_en    = cap_vld & clr_lat;
    assign sk_clr_addr  = sk_clr_en ? {beat_idx, cap_lane} : '0;

    // Datapath: lane counter, beat packer, sequence bookkeeping
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            beat_idx   <= '0;
            rd_cnt     <= '0;
            cap_vld    <= 1'b0;
            cap_lane   <= '0;
            clr_lat    <= 1'b0;
            seq        <= '0;
            export_seq <= '0;
            beat       <= '0;
        end else begin
            cap_vld  <= sk_rd_en;
            cap_lane <= rd_cnt[LANE_W-1:0];
            if (cap_vld) beat[cap_lane] <= sk_rd_data;

            unique case (state)
                EXP_IDLE: if (export_start) begin
                    clr_lat  <= clear_on_read;
                    beat_idx <= '0;
                    rd_cnt   <= '0;
                end
                EXP_FILL: rd_cnt <= fill_end ? '0 : rd_cnt + 1'b1;
                EXP_SEND: if (handshake && beat_idx != LAST_BEAT)
                    beat_idx <= beat_idx + 1'b1;
                EXP_DONE: begin
                    export_seq <= seq;
                    seq        <= seq + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sketch_export.sv
// tb_sketch_export: directed bench for sketch_export with a behavioural
// sketch RAM (one-cycle read latency, zero-write port) and a stream monitor.
module tb_sketch_export;
    import sketch_pkg::*;

    logic        axis_aclk = 1'b0;
    logic        axis_resetn = 1'b0;
    logic        export_start = 1'b0;
    logic        clear_on_read = 1'b0;
    logic        export_busy, export_done;
    logic [15:0] export_seq;
    logic        sk_rd_en, sk_clr_en;
    logic [11:0] sk_rd_addr, sk_clr_addr;
    logic [31:0] sk_rd_data;

    sketch_export_if #(.DATA_W(512), .USER_W(128)) m_axis_if ();

    sketch_export dut (
        .axis_aclk     (axis_aclk),
        .axis_resetn   (axis_resetn),
        .export_start  (export_start),
        .clear_on_read (clear_on_read),
        .export_busy   (export_busy),
        .export_done   (export_done),
        .export_seq    (export_seq),
        .sk_rd_en      (sk_rd_en),
        .sk_rd_addr    (sk_rd_addr),
        .sk_rd_data    (sk_rd_data),
        .sk_clr_en     (sk_clr_en),
        .sk_clr_addr   (sk_clr_addr),
        .m_axis        (m_axis_if)
    );

    always #5 axis_aclk = ~axis_aclk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sketch RAM model
    logic [31:0] mem [0:4095];
    logic        preload = 1'b0;
    int          cyc = 0;
    always @(posedge axis_aclk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= i;
        end else begin
            if (sk_rd_en)  sk_rd_data <= mem[sk_rd_addr];
            if (sk_clr_en) mem[sk_clr_addr] <= 32'h0;
        end
    end

    // tready: 0 = always ready, 1 = random, 2 = held low
    int mode = 0;
    always @(posedge axis_aclk) begin
        #1;
        case (mode)
            1:       m_axis_if.tready = 1'($urandom_range(0, 1));
            2:       m_axis_if.tready = 1'b0;
            default: m_axis_if.tready = 1'b1;
        endcase
    end

    // Stream monitor: records handshaked beats and checks stall stability
    logic [511:0] beat_mem [0:299];
    logic         last_mem [0:299];
    int           nbeats, first_cyc, done_cyc, stall_cnt, stall_err;
    bit           done_seen;
    logic         mon_clr = 1'b0;
    logic         prev_stall;
    logic [511:0] prev_data;
    logic         prev_last;
    always @(negedge axis_aclk) begin
        if (mon_clr) begin
            nbeats = 0; first_cyc = -1; done_seen = 0; done_cyc = 0;
            stall_cnt = 0; stall_err = 0; prev_stall = 0;
        end else if (!axis_resetn) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                stall_cnt++;
                if (!(m_axis_if.tvalid && m_axis_if.tdata == prev_data &&
                      m_axis_if.tlast == prev_last))
                    stall_err++;
            end
            if (m_axis_if.tvalid && first_cyc < 0) first_cyc = cyc;
            if (m_axis_if.tvalid && m_axis_if.tready && nbeats < 300) begin
                beat_mem[nbeats] = m_axis_if.tdata;
                last_mem[nbeats] = m_axis_if.tlast;
                nbeats++;
            end
            if (export_done) begin done_seen = 1; done_cyc = cyc; end
            prev_stall = m_axis_if.tvalid && !m_axis_if.tready;
            prev_data  = m_axis_if.tdata;
            prev_last  = m_axis_if.tlast;
        end
    end

    task automatic do_preload();
        @(posedge axis_aclk); #1 preload = 1'b1;
        @(posedge axis_aclk); #1 preload = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge axis_aclk); #1 mon_clr = 1'b0;
    endtask

    // Launch an export and wait (bounded) for export_done.
    task automatic do_export(input bit clr, input int mode_i, input bit poke);
        int n;
        clear_mon();
        @(posedge axis_aclk); #1;
        mode = mode_i; export_start = 1'b1; clear_on_read = clr;
        @(negedge axis_aclk);
        chk("idle_before_start", m_axis_if.tvalid, 1'b0);
        @(posedge axis_aclk); #1;
        export_start = 1'b0; clear_on_read = 1'b0;
        @(negedge axis_aclk);
        chk("hdr_latency", m_axis_if.tvalid, 1'b1);
        n = 0;
        while (!done_seen && n < 30000) begin
            @(posedge axis_aclk); n++;
            if (poke && n == 500) begin
                #1 export_start = 1'b1;
                @(posedge axis_aclk); #1 export_start = 1'b0; n++;
            end
        end
        chk("done_timeout", done_seen, 1'b1);
        repeat (2) @(posedge axis_aclk);
    endtask

    task automatic verify_frame(input logic [15:0] eseq);
        logic [511:0] h;
        int derr, lerr;
        chk("beat_count", nbeats, 257);
        h = beat_mem[0];
        chk("hdr_magic", h[31:0], 32'h534B4554);
        chk("hdr_seq", h[47:32], eseq);
        chk("hdr_rows", h[63:48], 16'd4);
        chk("hdr_width", h[95:64], 32'd1024);
        chk("hdr_pad", |h[511:96], 1'b0);
        h = beat_mem[1];
        chk("b1_lane0", h[31:0], 0);
        chk("b1_lane15", h[511:480], 15);
        h = beat_mem[256];
        chk("b256_lane15", h[511:480], 4095);
        derr = 0; lerr = 0;
        for (int b = 0; b <= 256; b++) begin
            if (last_mem[b] !== (b == 256)) lerr++;
            if (b > 0)
                for (int k = 0; k < 16; k++)
                    if (beat_mem[b][32*k +: 32] !== 32'(16*(b-1) + k)) derr++;
        end
        chk("data_errs", derr, 0);
        chk("tlast_pos", lerr, 0);
        chk("export_seq", export_seq, eseq);
        chk("busy_after", export_busy, 1'b0);
    endtask

    initial begin
        int n;
        m_axis_if.tready = 1'b1;
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk("rst_tvalid", m_axis_if.tvalid, 1'b0);
        chk("rst_tlast", m_axis_if.tlast, 1'b0);
        chk("rst_tkeep", m_axis_if.tkeep, 64'h0);
        chk("rst_tdata", |m_axis_if.tdata, 1'b0);
        chk("rst_tuser_lo", m_axis_if.tuser[63:0], 64'h0000_0000_0200_0000);
        chk("rst_tuser_hi", m_axis_if.tuser[127:64], 64'h0);
        chk("rst_busy", export_busy, 1'b0);
        chk("rst_done", export_done, 1'b0);
        chk("rst_seq", export_seq, 16'h0);
        chk("rst_rd_en", sk_rd_en, 1'b0);
        chk("rst_clr_en", sk_clr_en, 1'b0);
        #1 axis_resetn = 1'b1;

        // Run A: plain export, always ready
        do_preload();
        do_export(1'b0, 0, 1'b0);
        verify_frame(16'd0);
        chk("frame_cycles", done_cyc - first_cyc, 4609);
        n = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== 32'(i)) n++;
        chk("mem_untouched", n, 0);

        // Run B: clear on read
        do_preload();
        do_export(1'b1, 0, 1'b0);
        verify_frame(16'd1);
        n = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== 32'h0) n++;
        chk("mem_cleared_nonzero", n, 0);

        // Run C: random backpressure plus a stray start mid-frame
        do_preload();
        do_export(1'b0, 1, 1'b1);
        verify_frame(16'd2);
        chk("stalls_seen", stall_cnt > 0, 1'b1);
        chk("stall_stability", stall_err, 0);
        repeat (40) @(posedge axis_aclk);
        chk("no_extra_frame", nbeats, 257);
        chk("idle_after_c", export_busy, 1'b0);

        // Reset during a stall at beat 100
        mode = 0;
        do_preload();
        clear_mon();
        @(posedge axis_aclk); #1 export_start = 1'b1;
        @(posedge axis_aclk); #1 export_start = 1'b0;
        n = 0;
        while (nbeats < 100 && n < 5000) begin @(negedge axis_aclk); n++; end
        chk("reach_beat100", nbeats >= 100, 1'b1);
        mode = 2;
        n = 0;
        do begin @(negedge axis_aclk); n++; end
        while (!(m_axis_if.tvalid && !m_axis_if.tready) && n < 100);
        chk("stall_reached", m_axis_if.tvalid && !m_axis_if.tready, 1'b1);
        axis_resetn = 1'b0;
        #1;
        chk("rst_mid_tvalid", m_axis_if.tvalid, 1'b0);
        chk("rst_mid_busy", export_busy, 1'b0);
        chk("rst_mid_tlast", m_axis_if.tlast, 1'b0);
        chk("rst_mid_seq", export_seq, 16'h0);
        repeat (2) @(posedge axis_aclk);
        #1 axis_resetn = 1'b1;
        mode = 0;
        do_preload();
        do_export(1'b0, 0, 1'b0);
        verify_frame(16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sketch_export.md
# sketch_export

Reader side of the count-min sketch kept in the output port lookup. On a start pulse it walks every counter of the ROWS×WIDTH sketch memory through a one-cycle-latency read port, packs counters into 512-bit beats and emits one AXI-Stream frame toward the CPU DMA port. It can optionally zero each counter as it is read, giving an atomic snapshot-and-reset per measurement epoch. It sits beside the lookup block and shares the sketch RAM's second port.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 512, stream data width; fixed at 512.
- C_M_AXIS_TUSER_WIDTH, 128, tuser width.
- DST_PORT_POS, 24, LSB of the one-hot destination port field in tuser.
- EXPORT_DST_PORT, 8'h02, destination field value; nf0 CPU queue.
- ROWS, 4, sketch rows.
- WIDTH, 1024, counters per row.
- CNT_WIDTH, 32, counter width.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  reset; asynchronous, active-low.
- export_start  in  1  one-cycle pulse requesting an export.
- clear_on_read  in  1  sampled at accepted start; zero each counter after it is read.
- export_busy  out  1  high from accepted start until done; the sketch updater suspends updates while high.
- export_done  out  1  one-cycle pulse after the final beat handshake.
- export_seq  out  16  sequence number of the last completed export.
- sk_rd_en  out  1  sketch read enable.
- sk_rd_addr  out  12  flat address, row*WIDTH+col.
- sk_rd_data  in  32  read data, valid the cycle after sk_rd_en.
- sk_clr_en  out  1  zero-write enable.
- sk_clr_addr  out  12  zero-write address.
- m_axis_tdata  out  512  frame data.
- m_axis_tkeep  out  64  always all ones while tvalid.
- m_axis_tuser  out  128  zero except [DST_PORT_POS+:8]=EXPORT_DST_PORT.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  final beat.

## Operation
- FSM states: IDLE, HEADER, FILL, SEND, DONE.
- IDLE:
  - export_start latches clear_on_read, asserts export_busy and moves to HEADER.
  - export_start in any other state is ignored.
- HEADER: present header beat (tvalid=1). On handshake go to FILL.
  - Header bits [31:0]=32'h534B4554 ("SKET").
  - [47:32]=current seq.
  - [63:48]=ROWS.
  - [95:64]=WIDTH.
  - Remaining bits zero.
- FILL: issue 16 consecutive reads at addresses 16b..16b+15 for data beat b (b=0..255).
  - Capture sk_rd_data one cycle later into lane k, bits [32k+31:32k], for address 16b+k.
  - If clear_on_read, assert sk_clr_en with sk_clr_addr=16b+k in the capture cycle.
  - After the 16th capture, go to SEND.
- SEND: tvalid=1 holding the packed beat; tlast=1 when b=255.
  - On handshake, b<255 increments b and returns to FILL.
  - On handshake, b=255 goes to DONE.
- DONE: pulse export_done, export_seq<=seq, seq<=seq+1 (wraps 16'hFFFF→0), deassert busy, return to IDLE.
- Frame length: 257 beats (1 header + 4096/16).
- Counters are emitted verbatim; no saturation or arithmetic.

## Timing
- Reset values:
  - all outputs 0, except m_axis_tuser dst field, which is constant.
  - seq=0, export_seq=0, FSM=IDLE.
- Start accepted in cycle t: header tvalid in t+1.
- Per data beat with tready=1: 16 read cycles + 1 capture-drain cycle + 1 SEND cycle = 18 cycles.
- Full frame with tready held high: 1 + 256×18 = 4609 cycles from first tvalid to last handshake; export_done follows 1 cycle later.
- AXIS rules:
  - tdata, tlast and tuser stay stable while tvalid && !tready.
  - tvalid never drops without a handshake, except under reset.
  - No reads are issued in SEND, so backpressure needs no skid storage.
- Clear write lands one cycle after the read of the same address; there is no read-after-clear hazard because every address is read once.
- Reset mid-frame: immediate return to reset values. The truncated frame is abandoned with no tlast; seq is not incremented.
- export_start and the final handshake in the same cycle: start ignored (block is busy).

## Structure
- Package sketch_pkg:
  - ROWS, WIDTH, CNT_WIDTH.
  - SKETCH_ADDR_W=$clog2(ROWS*WIDTH).
  - SKETCH_MAGIC=32'h534B4554.
  - LANES=16.
  - Export FSM state enum.
  - The lookup block imports the same package.
- No sub-module. The beat packer is a 16-lane register with a 4-bit lane counter, kept in this module.

## Test plan
- Memory preloaded with value = address, clear_on_read=0, tready=1, one start:
  - 257 beats; header word0=0x534B4554, seq=0, ROWS=4, WIDTH=1024.
  - Beat 1 lane 0=0, lane 15=15; beat 256 lane 15=4095.
  - tlast only on beat 256; export_done at cycle 4610; export_seq=0.
- Same run with clear_on_read=1: frame identical; afterward all 4096 memory words read 0.
- Random tready (50% duty): data identical to the first run, and tdata stable on every stalled cycle.
- export_start pulsed mid-frame: no second header and no effect on the current frame. Three back-to-back exports report seq 0, 1, 2.
- axis_resetn asserted at beat 100 during a stall: tvalid=0 immediately, busy=0, seq=0. A following export starts a fresh header with seq=0.
